addsub_seq_ctrl: RTL and testbench
==================================

// Module: addsub_seq_ctrl
// PURPOSE
//  Multi-cycle controller that sequences one SLICE-bit add/sub slice over WIDTH-bit operands.
//  Carry/borrow ripples slice-to-slice through a register, one slice per cycle, LSB first.
//  Sits beside the EX stage as the shared wide-arithmetic unit, with valid/ready request and result handshakes.
//  Produces sum/difference, carry (add) or borrow (sub), zero and optional signed overflow.
// PARAMETERS
//  WIDTH  32  operand/result width; must be an integer multiple of SLICE
//  SLICE  4   bits processed per cycle; N = WIDTH/SLICE slices per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  req_valid  in   1      request present; a, b, op_sub qualified by it
//  req_ready  out  1      controller can accept; high only in IDLE, forced 0 while rst_n=0
//  op_sub     in   1      0: a+b, 1: a-b
//  a, b       in   WIDTH  operands
//  res_valid  out  1      result valid; held until res_ready
//  res_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum or difference, modulo 2^WIDTH
//  carry      out  1      add: carry out of MSB; sub: borrow (1 iff a<b unsigned)
//  zero       out  1      result == 0
//  busy       out  1      state != IDLE
//  ovf        out  1      signed overflow; present only with ADDSUB_OVF_EN
// BEHAVIOUR
//  Reset (async): state=IDLE, res_valid=0, result=0, carry=0, zero=0, busy=0, ovf=0, slice count=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: req_ready=1. On req_valid&&req_ready at edge E0: latch a, b, op_sub; cin=0; cnt=0; go to RUN.
//   RUN: slice cnt computed from latched operands and cin; slice result registered into result[cnt*SLICE+:SLICE];
//        cin <= slice carry/borrow; cnt++. After slice N-1 is registered, go to DONE with carry = final cin.
//   DONE: res_valid=1; result/carry/zero/ovf held stable. On res_ready, go to IDLE at that edge.
//  Latency: res_valid first high N cycles after the accepting edge E0 (4-bit case: N=1).
//  Throughput: one op per N+2 cycles minimum. No request accepted in RUN/DONE (req_ready=0).
//  Slice arithmetic (SLICE+1-bit): add {c,s} = a_s + b_s + cin; sub {w,d} = a_s - b_s - cin,
//   where w (bit SLICE of the wrapped result) is borrow-out.
//  Outputs update only on DONE entry; res_valid never pulses without the handshake completing.
//  Inputs are ignored after acceptance; changing a/b in RUN has no effect.
//  Reset mid-RUN/DONE: operation discarded; no res_valid is produced.
//  req_valid during reset deassertion: first accept occurs at the first edge with rst_n=1.
// CONFIGURATION
//  ADDSUB_OVF_EN defined: ovf port and logic present; add: a[MSB]==b[MSB] && result[MSB]!=a[MSB];
//   sub: a[MSB]!=b[MSB] && result[MSB]!=a[MSB]. Registered with the other flags on DONE entry.
//  ADDSUB_OVF_EN undefined: no ovf port, no overflow logic; all other behaviour identical.
// STRUCTURE
//  Shared package addsub_pkg: FSM state encoding (IDLE/RUN/DONE), OP_ADD/OP_SUB constants, default SLICE.
//  Sub-module addsub_slice (combinational, SLICE-bit): inputs a_s, b_s, cin, sub; outputs s, cout (carry or borrow).
//  addsub_seq_ctrl holds the FSM, slice counter, operand registers, cin register and result register.
// TESTING
//  WIDTH=4: add a=4'b1010, b=4'b0111 -> result=4'b0001, carry=1, zero=0, res_valid 1 cycle after accept.
//  WIDTH=4: sub a=4'b0001, b=4'b0100 -> result=4'b1101, carry(borrow)=1; sub 4-4 -> 0000, borrow=0, zero=1.
//  WIDTH=32: add 0xFFFFFFFF+0x00000001 -> result=0, carry=1, zero=1, res_valid exactly 8 cycles after accept.
//  WIDTH=32 with ADDSUB_OVF_EN: sub 0x80000000-0x00000001 -> 0x7FFFFFFF, borrow=0, ovf=1;
//   add 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//  Backpressure: res_ready low 5 cycles in DONE -> outputs stable, req_ready=0; new req accepted after handshake.
//  rst_n pulsed low mid-RUN -> immediate IDLE, res_valid=0, busy=0; next request computes correctly from cin=0.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/sub unit: FSM encoding,
// operation codes, default slice width and a counter-width helper.
// Optional feature macro used by the unit: ADDSUB_OVF_EN (signed overflow flag).
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int SLICE_DEFAULT = 4;

   // Slice counter width; a single-slice configuration still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit add/sub cell. In subtract mode cout is the
// borrow-out, taken as the top bit of the (SLICE+1)-bit wrapped difference.
module addsub_slice
   import addsub_pkg::*;
#(
   parameter int SLICE = SLICE_DEFAULT
) (
   input  logic [SLICE-1:0] a_s,
   input  logic [SLICE-1:0] b_s,
   input  logic             cin,
   input  logic             sub,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE:0] ext;

   // One extra bit holds the carry (add) or the borrow (sub).
   always_comb begin
      if (sub == OP_SUB) begin
         ext = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, cin};
      end else begin
         ext = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, cin};
      end
   end

   assign s    = ext[SLICE-1:0];
   assign cout = ext[SLICE];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-cycle wide add/sub: one SLICE-bit slice per cycle, LSB first, with the
// carry/borrow rippling through a register. Valid/ready on both request and
// result sides. Define ADDSUB_OVF_EN to add the signed-overflow output ovf.
module addsub_seq_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = SLICE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             busy
`ifdef ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = cnt_width(N);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;
   logic             cin_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic             res_valid_q;
   logic             ovf_d;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_s;
   logic             slice_cout;
   logic             last_slice;
   int               slice_base;

   // Select the current slice of the latched operands.
   always_comb begin
      slice_base = int'(cnt_q) * SLICE;
      slice_a    = a_q[slice_base +: SLICE];
      slice_b    = b_q[slice_base +: SLICE];
   end

   addsub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a_s  (slice_a),
      .b_s  (slice_b),
      .cin  (cin_q),
      .sub  (sub_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // Working result with the current slice merged in; on the last slice this
   // is the complete answer that gets published on DONE entry.
   always_comb begin
      acc_d = acc_q;
      acc_d[slice_base +: SLICE] = slice_s;
   end

   assign last_slice = (cnt_q == CW'(N - 1));

   // Signed overflow from operand signs and the final result sign.
   always_comb begin
      if (sub_q == OP_SUB) begin
         ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
      end else begin
         ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
      end
   end

`ifdef ADDSUB_OVF_EN
   logic ovf_q;
`endif

   // Controller FSM: accept in IDLE, ripple slices in RUN, hold result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= OP_ADD;
         cin_q       <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= op_sub;
                  cin_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q <= acc_d;
               cin_q <= slice_cout;
               cnt_q <= cnt_q + CW'(1);
               if (last_slice) begin
                  result_q    <= acc_d;
                  carry_q     <= slice_cout;
                  zero_q      <= (acc_d == '0);
                  res_valid_q <= 1'b1;
`ifdef ADDSUB_OVF_EN
                  ovf_q       <= ovf_d;
`endif
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Ready depends on rst_n directly so it is low throughout reset and high
   // at the very first edge after release.
   assign req_ready = rst_n && (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign res_valid = res_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
`ifdef ADDSUB_OVF_EN
   assign ovf       = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_d;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl: a 4-bit (single slice) and a 32-bit
// (eight slice) instance, hand-computed vectors, backpressure and resets.
module tb_addsub_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   // 4-bit instance
   logic        rv4 = 1'b0, op4 = 1'b0, rr4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        rdy4, vld4, c4, z4, busy4;
   logic [3:0]  res4;
   // 32-bit instance
   logic        rv32 = 1'b0, op32 = 1'b0, rr32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        rdy32, vld32, c32, z32, busy32;
   logic [31:0] res32;
`ifdef ADDSUB_OVF_EN
   logic        ovf4, ovf32;
`endif

   addsub_seq_ctrl #(.WIDTH(4), .SLICE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rdy4), .op_sub(op4),
      .a(a4), .b(b4), .res_valid(vld4), .res_ready(rr4), .result(res4),
      .carry(c4), .zero(z4), .busy(busy4)
`ifdef ADDSUB_OVF_EN
      , .ovf(ovf4)
`endif
   );

   addsub_seq_ctrl #(.WIDTH(32), .SLICE(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv32), .req_ready(rdy32), .op_sub(op32),
      .a(a32), .b(b32), .res_valid(vld32), .res_ready(rr32), .result(res32),
      .carry(c32), .zero(z32), .busy(busy32)
`ifdef ADDSUB_OVF_EN
      , .ovf(ovf32)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Present one request at a negedge; return #1 after the accepting edge
   // with the operand inputs scrambled.
   task automatic issue(input bit sel, input logic sub, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      chk("req_ready in idle", sel ? 32'(rdy32) : 32'(rdy4), 32'd1);
      if (sel) begin
         rv32 = 1'b1; op32 = sub; a32 = av; b32 = bv;
      end else begin
         rv4 = 1'b1; op4 = sub; a4 = av[3:0]; b4 = bv[3:0];
      end
      @(posedge clk);
      #1;
      rv4  = 1'b0;
      rv32 = 1'b0;
      a32  = $urandom;
      b32  = $urandom;
      a4   = 4'($urandom);
      b4   = 4'($urandom);
   endtask

   // Wait for the result, check it, optionally hold off res_ready, handshake.
   task automatic collect(input bit sel, input string name, input logic [31:0] er,
                          input logic ec, input logic ez, input logic eo,
                          input int elat, input int bp);
      int cyc = 0;
      bit got = 1'b0;
      logic [31:0] r;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (sel ? vld32 : vld4) got = 1'b1;
      end
      chk({name, " res_valid seen"}, 32'(got), 32'd1);
      chk({name, " latency"}, 32'(cyc), 32'(elat));
      r = sel ? res32 : {28'd0, res4};
      chk({name, " result"}, r, er);
      chk({name, " carry"}, sel ? 32'(c32) : 32'(c4), 32'(ec));
      chk({name, " zero"}, sel ? 32'(z32) : 32'(z4), 32'(ez));
`ifdef ADDSUB_OVF_EN
      chk({name, " ovf"}, sel ? 32'(ovf32) : 32'(ovf4), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
      chk({name, " busy in done"}, sel ? 32'(busy32) : 32'(busy4), 32'd1);
      chk({name, " req_ready in done"}, sel ? 32'(rdy32) : 32'(rdy4), 32'd0);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         #1;
         chk({name, " held result"}, sel ? res32 : {28'd0, res4}, er);
         chk({name, " held valid"}, sel ? 32'(vld32) : 32'(vld4), 32'd1);
         chk({name, " held ready"}, sel ? 32'(rdy32) : 32'(rdy4), 32'd0);
      end
      if (sel) rr32 = 1'b1; else rr4 = 1'b1;
      @(posedge clk);
      #1;
      rr32 = 1'b0;
      rr4  = 1'b0;
      chk({name, " valid after hs"}, sel ? 32'(vld32) : 32'(vld4), 32'd0);
      chk({name, " busy after hs"}, sel ? 32'(busy32) : 32'(busy4), 32'd0);
      chk({name, " ready after hs"}, sel ? 32'(rdy32) : 32'(rdy4), 32'd1);
      $display("txn %-22s w=%0d result=0x%0h exp=0x%0h latency=%0d", name, sel ? 32 : 4, r, er, cyc);
   endtask

   initial begin
      // Request already pending while reset is held.
      rv32 = 1'b1; op32 = 1'b0; a32 = 32'd1; b32 = 32'd2;
      repeat (2) @(negedge clk);
      chk("reset req_ready32", 32'(rdy32), 32'd0);
      chk("reset req_ready4", 32'(rdy4), 32'd0);
      chk("reset res_valid", 32'(vld32), 32'd0);
      chk("reset result", res32, 32'd0);
      chk("reset carry", 32'(c32), 32'd0);
      chk("reset zero", 32'(z32), 32'd0);
      chk("reset busy", 32'(busy32), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("ready at release", 32'(rdy32), 32'd1);
      @(posedge clk);
      #1;
      rv32 = 1'b0;
      collect(1'b1, "release 1+2", 32'd3, 1'b0, 1'b0, 1'b0, 8, 0);
      chk("dut4 idle", 32'(busy4), 32'd0);

      // Single-slice vectors
      issue(1'b0, 1'b0, 32'hA, 32'h7);
      collect(1'b0, "w4 add A+7", 32'h1, 1'b1, 1'b0, 1'b0, 1, 0);
      issue(1'b0, 1'b1, 32'h1, 32'h4);
      collect(1'b0, "w4 sub 1-4", 32'hD, 1'b1, 1'b0, 1'b0, 1, 0);
      issue(1'b0, 1'b1, 32'h4, 32'h4);
      collect(1'b0, "w4 sub 4-4", 32'h0, 1'b0, 1'b1, 1'b0, 1, 0);

      // Eight-slice vectors
      issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      collect(1'b1, "w32 FFFFFFFF+1", 32'h0, 1'b1, 1'b1, 1'b0, 8, 0);
      issue(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
      collect(1'b1, "w32 80000000-1", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 8, 0);
      issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
      collect(1'b1, "w32 7FFFFFFF+1", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 8, 0);
      issue(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007);
      collect(1'b1, "w32 5-7", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 8, 0);
      issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      collect(1'b1, "w32 bp 12345678+9ABCDEF0", 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 8, 5);
      issue(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001);
      collect(1'b1, "w32 after bp 10-1", 32'h0000_000F, 1'b0, 1'b0, 1'b0, 8, 0);

      // Reset in the middle of RUN discards the operation.
      issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("busy mid run", 32'(busy32), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid-run rst busy", 32'(busy32), 32'd0);
      chk("mid-run rst valid", 32'(vld32), 32'd0);
      chk("mid-run rst ready", 32'(rdy32), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("no valid after rst", 32'(vld32), 32'd0);
      end
      issue(1'b1, 1'b0, 32'h0000_000F, 32'h0000_0001);
      collect(1'b1, "post-rst F+1", 32'h0000_0010, 1'b0, 1'b0, 1'b0, 8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
